// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the
// pipeline write-back and a multi-cycle unit, with starvation and scoreboard.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 mc_valid,
  input  logic [ADDR_W-1:0]    mc_rd,
  input  logic [DATA_W-1:0]    mc_data,
  output logic                 mc_ready,
  input  logic                 mc_issue,
  input  logic [ADDR_W-1:0]    mc_issue_rd,
  output logic                 stall_pipe,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NREG = 2**ADDR_W;
  localparam int CW   = 4;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;
  logic [CW-1:0]   w_cnt_inc;
  logic            r_stall;
  logic            w_stall_nx;
  logic            w_grant;
  logic            w_refuse;
  logic            r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // During a forced stall the pipeline write is ignored entirely.
  assign w_grant   = mc_valid & (~wb_valid | r_stall);
  assign w_refuse  = mc_valid & ~w_grant;
  assign w_cnt_inc = r_cnt + CW'(1);

  assign mc_ready   = w_grant;
  assign stall_pipe = r_stall;
  assign rf_we      = r_we;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign pending    = r_pend;

  // State, starvation counter and stall register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_stall <= w_stall_nx;
    end
  end

  // Next state: count refusals, force one stall cycle at the limit.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_stall_nx = r_stall;
    unique case (r_state)
      IDLE: begin
        w_stall_nx = 1'b0;
        if (w_refuse) begin
          w_state_nx = WAIT;
          w_cnt_nx   = CW'(1);
        end else begin
          w_cnt_nx = '0;
        end
      end
      WAIT: begin
        if (w_refuse) begin
          if (w_cnt_inc >= LIM) begin
            w_state_nx = FORCE;
            w_stall_nx = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end else begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      end
      FORCE: begin
        w_state_nx = IDLE;
        w_stall_nx = 1'b0;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = IDLE;
        w_stall_nx = 1'b0;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Register file write port; address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_we    <= 1'b1;
      r_waddr <= mc_rd;
      r_wdata <= mc_data;
    end else if (wb_valid & ~r_stall) begin
      r_we    <= 1'b1;
      r_waddr <= wb_rd;
      r_wdata <= wb_data;
    end else begin
      r_we <= 1'b0;
    end
  end

  // Scoreboard set/clear masks.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (mc_issue) w_set[mc_issue_rd] = 1'b1;
    if (w_grant)  w_clr[mc_rd]       = 1'b1;
  end

  // Pending scoreboard; a same-cycle set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: vector table, corner sequences and
// randomized run against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int LIM = 4;
  localparam int DW  = 32;
  localparam int AW  = 4;

  logic          clk;
  logic          rst_n;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          mc_valid;
  logic [AW-1:0] mc_rd;
  logic [DW-1:0] mc_data;
  logic          mc_ready;
  logic          mc_issue;
  logic [AW-1:0] mc_issue_rd;
  logic          stall_pipe;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [15:0]   pending;

  regfile_wb_arbiter #(
    .STARVE_LIMIT(LIM),
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .mc_valid(mc_valid),
    .mc_rd(mc_rd),
    .mc_data(mc_data),
    .mc_ready(mc_ready),
    .mc_issue(mc_issue),
    .mc_issue_rd(mc_issue_rd),
    .stall_pipe(stall_pipe),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put(input logic wv, input logic [3:0] wrd,
                     input logic [31:0] wd, input logic mv,
                     input logic [3:0] mrd, input logic [31:0] md,
                     input logic iv, input logic [3:0] ird);
    wb_valid    = wv;
    wb_rd       = wrd;
    wb_data     = wd;
    mc_valid    = mv;
    mc_rd       = mrd;
    mc_data     = md;
    mc_issue    = iv;
    mc_issue_rd = ird;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wv;
    logic [3:0]  wrd;
    logic [31:0] wd;
    logic        mv;
    logic [3:0]  mrd;
    logic [31:0] md;
    logic        iv;
    logic [3:0]  ird;
    logic        e_rdy;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
    logic [15:0] e_pd;
  } vec_t;

  vec_t tbl[11];

  // behavioural model state
  logic        m_stall;
  int          m_refused;
  logic        m_we;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  logic [15:0] m_pd;
  logic        g;
  logic        hold;

  initial begin
    tbl[0]  = '{1, 3,  32'h1234, 0, 0, 0,      0, 0, 0, 1, 3,  32'h1234, 16'h0000};
    tbl[1]  = '{1, 15, 32'h0104, 0, 0, 0,      0, 0, 0, 1, 15, 32'h0104, 16'h0000};
    tbl[2]  = '{0, 0,  0,        1, 7, 32'hDEAD, 0, 0, 1, 1, 7,  32'hDEAD, 16'h0000};
    tbl[3]  = '{0, 0,  0,        0, 0, 0,      0, 0, 0, 0, 7,  32'hDEAD, 16'h0000};
    tbl[4]  = '{0, 0,  0,        0, 0, 0,      1, 5, 0, 0, 7,  32'hDEAD, 16'h0020};
    tbl[5]  = '{0, 0,  0,        1, 5, 32'h55, 1, 5, 1, 1, 5,  32'h0055, 16'h0020};
    tbl[6]  = '{0, 0,  0,        1, 5, 32'h66, 0, 0, 1, 1, 5,  32'h0066, 16'h0000};
    tbl[7]  = '{0, 0,  0,        1, 9, 32'h99, 1, 2, 1, 1, 9,  32'h0099, 16'h0004};
    tbl[8]  = '{1, 0,  32'hA5,   0, 0, 0,      0, 0, 0, 1, 0,  32'h00A5, 16'h0004};
    tbl[9]  = '{1, 1,  32'h11,   1, 4, 32'h44, 0, 0, 0, 1, 1,  32'h0011, 16'h0004};
    tbl[10] = '{0, 0,  0,        0, 0, 0,      0, 0, 0, 0, 1,  32'h0011, 16'h0004};

    rst_n = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_we", rf_we, 0);
    chk("reset_waddr", rf_waddr, 0);
    chk("reset_wdata", rf_wdata, 0);
    chk("reset_stall", stall_pipe, 0);
    chk("reset_pending", pending, 0);
    chk("reset_ready", mc_ready, 0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      put(tbl[i].wv, tbl[i].wrd, tbl[i].wd, tbl[i].mv,
          tbl[i].mrd, tbl[i].md, tbl[i].iv, tbl[i].ird);
      #2;
      chk($sformatf("vec%0d_ready", i), mc_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("vec%0d_waddr", i), rf_waddr, tbl[i].e_wa);
      chk($sformatf("vec%0d_wdata", i), rf_wdata, tbl[i].e_wd);
      chk($sformatf("vec%0d_stall", i), stall_pipe, 0);
      chk($sformatf("vec%0d_pending", i), pending, tbl[i].e_pd);
    end

    // starvation with wb_valid held high
    do_reset();
    for (int c = 0; c < LIM; c++) begin
      put(1, 4'(c + 1), 32'(c), 1, 6, 32'hBEEF, 0, 0);
      #2;
      chk($sformatf("starve%0d_ready", c), mc_ready, 0);
      chk($sformatf("starve%0d_stall", c), stall_pipe, 0);
      @(posedge clk);
      #1;
      chk($sformatf("starve%0d_waddr", c), rf_waddr, c + 1);
    end
    put(1, 8, 32'h8, 1, 6, 32'hBEEF, 0, 0);
    #2;
    chk("force_stall", stall_pipe, 1);
    chk("force_ready", mc_ready, 1);
    @(posedge clk);
    #1;
    chk("force_we", rf_we, 1);
    chk("force_waddr", rf_waddr, 6);
    chk("force_wdata", rf_wdata, 32'hBEEF);
    chk("force_stall_off", stall_pipe, 0);

    // mc_valid drops during the forced cycle
    for (int c = 0; c < LIM; c++) begin
      put(1, 2, 32'h22, 1, 3, 32'h33, 0, 0);
      @(posedge clk);
      #1;
    end
    put(1, 2, 32'h22, 0, 3, 32'h33, 0, 0);
    #2;
    chk("drop_stall", stall_pipe, 1);
    chk("drop_ready", mc_ready, 0);
    @(posedge clk);
    #1;
    chk("drop_we", rf_we, 0);
    chk("drop_stall_off", stall_pipe, 0);

    // asynchronous reset in the middle of FORCE
    put(0, 0, 0, 0, 0, 0, 1, 5);
    @(posedge clk);
    #1;
    chk("pre_rst_pending", pending, 16'h0020);
    for (int c = 0; c < LIM; c++) begin
      put(1, 1, 32'h1, 1, 9, 32'h9, 0, 0);
      @(posedge clk);
      #1;
    end
    chk("pre_rst_stall", stall_pipe, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_we", rf_we, 0);
    chk("midrst_stall", stall_pipe, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_ready", mc_ready, 0);
    do_reset();

    // randomized run against the behavioural model
    m_stall   = 0;
    m_refused = 0;
    m_we      = 0;
    m_wa      = 0;
    m_wd      = 0;
    m_pd      = 0;
    hold      = 0;
    for (int n = 0; n < 3000; n++) begin
      wb_valid    = ($urandom_range(0, 3) != 0);
      wb_rd       = 4'($urandom);
      wb_data     = $urandom;
      mc_issue    = ($urandom_range(0, 2) == 0);
      mc_issue_rd = 4'($urandom);
      if (hold && $urandom_range(0, 9) != 0) begin
        mc_valid = 1'b1;
      end else begin
        mc_valid = ($urandom_range(0, 1) == 1);
        mc_rd    = 4'($urandom);
        mc_data  = $urandom;
      end
      g = mc_valid && (!wb_valid || m_stall);
      #2;
      chk("rand_ready", mc_ready, g);
      @(posedge clk);
      if (g) begin
        m_we = 1;
        m_wa = mc_rd;
        m_wd = mc_data;
      end else if (wb_valid && !m_stall) begin
        m_we = 1;
        m_wa = wb_rd;
        m_wd = wb_data;
      end else begin
        m_we = 0;
      end
      if (g) m_pd[mc_rd] = 1'b0;
      if (mc_issue) m_pd[mc_issue_rd] = 1'b1;
      hold = mc_valid && !g;
      if (m_stall) begin
        m_stall   = 0;
        m_refused = 0;
      end else if (hold) begin
        m_refused++;
        if (m_refused >= LIM) begin
          m_stall   = 1;
          m_refused = 0;
        end
      end else begin
        m_refused = 0;
      end
      #1;
      chk("rand_we", rf_we, m_we);
      chk("rand_waddr", rf_waddr, m_wa);
      chk("rand_wdata", rf_wdata, m_wd);
      chk("rand_stall", stall_pipe, m_stall);
      chk("rand_pending", pending, m_pd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the in-order pipeline write-back (ALU result, load result or call return address, already resolved to rd/data) and an out-of-order multi-cycle unit (multiply/divide). Pipeline writes have priority; a starvation counter forces a one-cycle pipeline stall so a waiting multi-cycle result is always retired. A pending-destination scoreboard tells the hazard unit which registers still await a multi-cycle result. The block sits between the write-back stage and the register file write port (a3/d3/we).

## Interface
- STARVE_LIMIT, 4: consecutive cycles a multi-cycle result may be refused before a forced grant (legal range 1..15)
- DATA_W, 32: register data width
- ADDR_W, 4: register address width (16 registers; r15 is the return-address register)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  pipeline has a write this cycle
- wb_rd  in  ADDR_W  pipeline destination (15 for call)
- wb_data  in  DATA_W  pipeline write data
- mc_valid  in  1  multi-cycle result available
- mc_rd  in  ADDR_W  multi-cycle destination
- mc_data  in  DATA_W  multi-cycle result
- mc_ready  out  1  multi-cycle result accepted this cycle (combinational)
- mc_issue  in  1  multi-cycle op issued this cycle
- mc_issue_rd  in  ADDR_W  destination of issued op
- stall_pipe  out  1  pipeline must hold write-back this cycle (registered)
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  ADDR_W  register file write address (registered)
- rf_wdata  out  DATA_W  register file write data (registered)
- pending  out  2**ADDR_W  bit i set while a multi-cycle write to ri is outstanding (registered)

## Operation
- States: IDLE (no mc result waiting), WAIT (mc_valid refused, counting), FORCE (stall_pipe high, mc granted).
- Grant: mc_ready = mc_valid & (!wb_valid | stall_pipe). While stall_pipe=1 the pipeline write is ignored; pipeline re-presents it next cycle.
- Write port next value: if stall_pipe & mc_valid -> mc; else if wb_valid -> wb; else if mc_valid -> mc; else rf_we=0 (addr/data hold).
- IDLE -> WAIT when mc_valid & !mc_ready; wait_cnt <= 1.
- WAIT: refused again -> wait_cnt+1; if incremented value reaches STARVE_LIMIT -> FORCE, stall_pipe <= 1, wait_cnt <= 0. Granted or mc_valid dropped -> IDLE, wait_cnt <= 0.
- FORCE lasts exactly one cycle: mc granted, then -> IDLE, stall_pipe <= 0. If mc_valid dropped during FORCE, no write, still -> IDLE.
- Scoreboard: mc_issue sets pending[mc_issue_rd]; mc grant clears pending[mc_rd]. Same register set and clear same cycle -> set wins. Different registers -> both apply.
- No suppression of any register; r0 written like any other.

## Timing
- Reset (rst_n low, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0, pending=0, wait_cnt=0, state IDLE. mc_ready follows its equation (0 when mc_valid=0).
- Write latency: request accepted in cycle N -> rf_we/rf_waddr/rf_wdata valid during cycle N+1, one write per cycle max.
- mc handshake: result transferred on a rising edge where mc_valid & mc_ready; mc unit holds mc_rd/mc_data stable until then.
- Starvation bound: with wb_valid continuously 1, a mc result is written at most STARVE_LIMIT+2 cycles after mc_valid rises.
- pending reflects set/clear one cycle after the issue/grant edge.
- Reset mid-WAIT/FORCE: state, counter, scoreboard cleared; mc unit must re-present after reset.

## Test plan
- Reset: drive rst_n=0 mid-FORCE -> rf_we=0, stall_pipe=0, pending=0 immediately, without a clock edge.
- Pipeline only: wb_valid=1, wb_rd=3, wb_data=0x1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234; call with wb_rd=15, data=pc+4=0x104 -> r15=0x104.
- Idle port: wb_valid=0, mc_valid=1, mc_rd=7, mc_data=0xDEAD -> mc_ready=1 same cycle, rf write r7=0xDEAD next cycle.
- Starvation: STARVE_LIMIT=4, wb_valid=1 always, mc_valid=1 from cycle 0 -> mc_ready=0 cycles 0-3, stall_pipe=1 in cycle 4 with mc_ready=1, mc write visible cycle 5, stall_pipe=0 cycle 5.
- Scoreboard: mc_issue rd=5 -> pending[5]=1; later grant mc_rd=5 with simultaneous mc_issue rd=5 -> pending[5] stays 1; grant rd=5 alone -> pending[5]=0.
